// File: rtl/stream_flow_ctrl.sv
// Flow controller for the DDS chain: FIFO reset settle, output priming, DSP pacing, drain, error counting.
// Registered state, levels and counters; dsp_en is combinational and stalls on an empty input or full output FIFO.
module stream_flow_ctrl #(
   parameter int DEPTH_IN      = 512,
   parameter int DEPTH_OUT     = 512,
   parameter int PRIME_WORDS   = 16,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16,
   localparam int IN_W         = $clog2(DEPTH_IN) + 1,
   localparam int OUT_W        = $clog2(DEPTH_OUT) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             clear_err,
   input  logic             wr_rst_busy,
   input  logic             rd_rst_busy,
   input  logic             in_wr,
   input  logic             out_rd,
   output logic             ds_en,
   output logic             dsp_en,
   output logic             interp_en,
   output logic [2:0]       state,
   output logic [IN_W-1:0]  in_level,
   output logic [OUT_W-1:0] out_level,
   output logic [CNT_W-1:0] ovf_cnt,
   output logic [CNT_W-1:0] unf_cnt,
   output logic             fault
);

   localparam int ST_W = $clog2(SETTLE_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_PRIME = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t          cur_state;
   state_t          nxt_state;
   logic [ST_W-1:0] settle_cnt;
   logic            settle_done;
   logic            chain_active;
   logic            ovf;
   logic            unf;
   logic            in_inc;
   logic            out_dec;
   logic            in_empty;
   logic            out_empty;
   logic            out_full;

   assign settle_done = settle_cnt >= ST_W'(SETTLE_CYCLES - 1);
   assign in_empty    = in_level == '0;
   assign out_empty   = out_level == '0;
   assign out_full    = out_level == OUT_W'(DEPTH_OUT);

   assign dsp_en  = chain_active && !in_empty && !out_full && !rd_rst_busy;
   assign ovf     = in_wr && (in_level == IN_W'(DEPTH_IN)) && !dsp_en;
   assign unf     = out_rd && out_empty;
   assign in_inc  = in_wr && !ovf;
   assign out_dec = out_rd && !unf;
   assign state   = cur_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_WAIT;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_WAIT: begin
            if (settle_done && !wr_rst_busy && !rd_rst_busy) nxt_state = S_IDLE;
         end
         S_IDLE: begin
            if (run_req) nxt_state = S_PRIME;
         end
         S_PRIME: begin
            if (unf)                                          nxt_state = S_PRIME;
            else if (!run_req)                                nxt_state = S_DRAIN;
            else if (out_level >= OUT_W'(PRIME_WORDS))        nxt_state = S_RUN;
         end
         S_RUN: begin
            if (unf)           nxt_state = S_PRIME;
            else if (!run_req) nxt_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (run_req)                   nxt_state = S_PRIME;
            else if (in_empty && out_empty) nxt_state = S_IDLE;
         end
         default: nxt_state = S_WAIT;
      endcase
   end

   always_comb begin
      ds_en        = 1'b0;
      interp_en    = 1'b0;
      chain_active = 1'b0;
      case (cur_state)
         S_PRIME: begin
            ds_en        = 1'b1;
            chain_active = 1'b1;
         end
         S_RUN: begin
            ds_en        = 1'b1;
            interp_en    = 1'b1;
            chain_active = 1'b1;
         end
         S_DRAIN: begin
            interp_en    = !out_empty;
            chain_active = 1'b1;
         end
         default: ;
      endcase
   end

   // Settle counter saturates rather than restarting, so a late busy pulse only delays exit
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
      end else if (cur_state == S_WAIT && !settle_done) begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_level  <= '0;
         out_level <= '0;
      end else begin
         in_level  <= in_level + IN_W'(in_inc) - IN_W'(dsp_en);
         out_level <= out_level + OUT_W'(dsp_en) - OUT_W'(out_dec);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_err) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
         fault   <= 1'b0;
      end else begin
         if (ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
         if (unf && unf_cnt != '1) unf_cnt <= unf_cnt + 1'b1;
         if (ovf || unf)           fault   <= 1'b1;
      end
   end

endmodule

// File: doc/stream_flow_ctrl.md
# stream_flow_ctrl

Flow controller for the DDS test datapath: downsampler → input FIFO → DSP stage → output FIFO → interpolator → DAC. It holds the chain idle until the FIFOs leave reset, then primes the output FIFO before releasing the interpolator. It paces DSP transfers from internally tracked FIFO occupancy and drains the pipeline cleanly on stop. It also counts and flags overflow and underflow events. It sits in the top level, in place of the ad-hoc almost-flag wiring between the FIFOs, the DSP stage and the interpolator.

## Interface
- DEPTH_IN, 512: input FIFO capacity in words.
- DEPTH_OUT, 512: output FIFO capacity in words.
- PRIME_WORDS, 16: output FIFO level required before interpolation starts (1..DEPTH_OUT).
- SETTLE_CYCLES, 16: minimum wait after reset before leaving WAIT.
- CNT_W, 16: error counter width.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- run_req  in  1  level; 1 = stream, 0 = stop and drain.
- clear_err  in  1  one-cycle pulse; clears both error counters and fault.
- wr_rst_busy  in  1  input FIFO write-side reset busy.
- rd_rst_busy  in  1  input FIFO read-side reset busy.
- in_wr  in  1  downsampler write strobe into the input FIFO.
- out_rd  in  1  interpolator read strobe from the output FIFO.
- ds_en  out  1  downsampler enable.
- dsp_en  out  1  input FIFO read + DSP + output FIFO write, one word per cycle.
- interp_en  out  1  interpolator enable.
- state  out  3  WAIT=0, IDLE=1, PRIME=2, RUN=3, DRAIN=4.
- in_level  out  clog2(DEPTH_IN)+1  tracked input FIFO occupancy.
- out_level  out  clog2(DEPTH_OUT)+1  tracked output FIFO occupancy.
- ovf_cnt  out  CNT_W  input overflow count; saturating.
- unf_cnt  out  CNT_W  output underflow count; saturating.
- fault  out  1  sticky; set on any overflow or underflow.

## Operation
- **Reset values.** state=WAIT; all enables 0; levels 0; counters 0; fault 0.
- **WAIT.** A settle counter runs from 0. Go to IDLE when the counter is ≥ SETTLE_CYCLES-1 and both wr_rst_busy and rd_rst_busy are 0. If a busy signal reasserts, the counter holds; it does not restart.
- **IDLE.** All enables 0. When run_req=1, go to PRIME.
- **PRIME.** ds_en=1 and interp_en=0; dsp_en is active per the rule below.
  - When out_level ≥ PRIME_WORDS, go to RUN.
  - When run_req=0, go to DRAIN.
- **RUN.** ds_en=1 and interp_en=1.
  - When run_req=0, go to DRAIN.
  - On an underflow event, go to PRIME to re-prime.
- **DRAIN.** ds_en=0. dsp_en continues while in_level>0. interp_en=1 while out_level>0.
  - When both levels are 0, go to IDLE.
  - If run_req returns to 1, go to PRIME.
- **dsp_en** (combinational) = (state is PRIME, RUN or DRAIN) AND in_level≠0 AND out_level≠DEPTH_OUT AND rd_rst_busy=0.
- **ds_en and interp_en** are decoded from the state register, plus out_level in DRAIN.
- **in_level** next = in_level + (in_wr AND NOT overflow) − dsp_en.
- **out_level** next = out_level + dsp_en − (out_rd AND NOT underflow).
- **Simultaneous increment and decrement** leave the level unchanged. Levels never wrap.
- **Overflow** = in_wr while in_level=DEPTH_IN and dsp_en=0. **Underflow** = out_rd while out_level=0.
  - Each event increments its counter, saturating at 2^CNT_W−1, and sets fault.
- **clear_err** in the same cycle as an event: clear wins.
- **State priority** when several conditions hold in one cycle: underflow → PRIME, then run_req=0 → DRAIN, then the prime threshold.

## Timing
- State, levels, counters and fault are registered and update on the clk edge after the cause.
- in_wr or dsp_en at edge N is reflected in in_level after edge N.
- The earliest dsp_en is the cycle after in_level first becomes nonzero.
- interp_en rises one cycle after the edge on which out_level reaches PRIME_WORDS.
- ds_en falls one cycle after the edge on which run_req=0 is sampled.
- rst asserted in any state gives reset values on the next edge. Levels restart at 0, matching the FIFOs' synchronous reset.

## Test plan
- Reset, busy held 40 cycles → state stays WAIT for 40 cycles, then IDLE one cycle after busy falls; SETTLE=16 is already satisfied.
- run_req=1, in_wr every 4th cycle → PRIME; interp_en rises one cycle after out_level reaches 16; fault stays 0.
- In RUN, force out_rd every cycle with in_wr 1/4 rate → underflow: unf_cnt=1, fault=1, state returns to PRIME, interp_en=0.
- Force in_wr every cycle with rd_rst_busy=1 for 520 cycles → in_level saturates at 512; ovf_cnt=8; clear_err → counters 0 and fault 0.
- Drop run_req in RUN with in_level=5, out_level=20 → DRAIN; ds_en=0; 5 dsp_en pulses; IDLE once both levels reach 0.
- Assert rst mid-RUN → next cycle state=WAIT with all outputs at reset values.
